lerp_pipe: RTL and testbench
============================

LERP_PIPE -- requirements
Module: lerp_pipe

Interface
REQ-001 Parameter DW, default 8, pixel width (unsigned).
REQ-002 Parameter FW, default 8, fraction width; frac is unsigned Q0.FW with range [0, 1-2^-FW].
REQ-003 Parameter CW, default 16, saturation-event counter width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 s_valid  in  1  input sample valid.
REQ-007 s_ready  out  1  stage can accept the input sample.
REQ-008 p0  in  DW  unsigned left sample.
REQ-009 p1  in  DW  unsigned right sample.
REQ-010 frac  in  FW  unsigned interpolation weight.
REQ-011 bias  in  DW  signed offset added after interpolation.
REQ-012 m_valid  out  1  output valid.
REQ-013 m_ready  in  1  downstream accepts the output.
REQ-014 y  out  DW  unsigned saturated result.
REQ-015 sat  out  1  y was clipped; qualified by m_valid.
REQ-016 sat_clr  in  1  clears sat_count.
REQ-017 sat_count  out  CW  number of saturated outputs accepted downstream.

Function
REQ-018 Result: y = clip(p0 + ((p1-p0)*frac + 2^(FW-1)) >>> FW + bias, 0, 2^DW-1); >>> is an arithmetic shift, so rounding is half-up toward +inf.
REQ-019 Stage 1 registers d = p1-p0 as a (DW+1)-bit signed value, together with p0, frac and bias.
REQ-020 Stage 2 registers the rounded product (DW+FW+2 bits signed), shifted right by FW.
REQ-021 Stage 3 registers the sum p0 + q + bias in a (DW+2)-bit signed value, then clips it; sat = 1 when the sum is below 0 or above 2^DW-1.
REQ-022 Each stage has a valid bit; a stage loads when it is empty or its successor loads in the same cycle (m_ready for stage 3).
REQ-023 Latency is 3 cycles from the accepting s_valid&s_ready edge to m_valid, with no backpressure; throughput is 1 sample per cycle.
REQ-024 s_ready = ~v1 | stage-2 load; it is combinational from m_ready through the stage enables, and there is no combinational path from s_valid to s_ready.
REQ-025 While m_valid=1 and m_ready=0, y and sat remain stable.
REQ-026 No sample is lost or duplicated; output order equals input order.
REQ-027 A transfer occurs only on m_valid&m_ready; sat_count increments by 1 on each transfer with sat=1.
REQ-028 sat_count saturates at 2^CW-1 and never wraps.
REQ-029 sat_clr has priority over a simultaneous increment; sat_count becomes 0 that cycle.
REQ-030 Data registers of empty stages hold their values and load nothing.

Reset
REQ-031 When rst_n=0 at a clock edge: all stage valid bits = 0, m_valid = 0, y = 0, sat = 0, sat_count = 0.
REQ-032 Reset mid-operation discards all in-flight samples; no output appears for them afterward.
REQ-033 s_ready = 1 in the first cycle after reset is released.

Structure
REQ-034 DW, FW and CW defaults, and the clip bounds, reside in the shared fixed-point math package alongside the adder and multiplier width rules.
REQ-035 The signed clip-to-unsigned-range logic is one sub-module, sat_clip_u, which is reused by later stages.
REQ-036 Arithmetic is written with explicit $signed casts and zero-extension of the unsigned operands; no mixed signed/unsigned expressions.

Verification
REQ-037 p0=10, p1=20, frac=128, bias=0 -> y=15, sat=0, m_valid exactly 3 cycles after acceptance.
REQ-038 p0=200, p1=100, frac=64, bias=0 -> product -6400, rounded shift -25, y=175, sat=0.
REQ-039 p0=250, p1=250, frac=0, bias=+50 -> y=255, sat=1, sat_count=1; then p0=5, frac=0, bias=-20 -> y=0, sat=1, sat_count=2.
REQ-040 Stream 10 samples with m_ready=0 for cycles 2..7 -> s_ready falls after 3 samples are held, all 10 outputs arrive in order, and y/sat are stable while stalled.
REQ-041 sat_count preloaded near max by forcing saturating samples, plus sat_clr asserted together with a saturated transfer -> count sticks at 2^CW-1, then reads 0 after the clear.
REQ-042 rst_n=0 for 1 cycle while 3 samples are in flight -> m_valid=0 next cycle, sat_count=0, none of the flushed samples emerge, and the next input emerges after 3 cycles.

Source files
------------

// File: rtl/lerp_pipe_pkg.sv
// Shared fixed-point math package: default widths, clip bounds and the
// width rules for the difference, product and sum datapaths.
package lerp_pipe_pkg;

  localparam int unsigned DefDw = 8;
  localparam int unsigned DefFw = 8;
  localparam int unsigned DefCw = 16;

  // Lower clip bound for unsigned outputs.
  localparam int ClipLo = 0;

  // Upper clip bound for an unsigned result of width dw.
  function automatic int unsigned clip_hi(input int unsigned dw);
    return (32'd1 << dw) - 32'd1;
  endfunction

  // Signed difference of two unsigned dw-bit operands.
  function automatic int unsigned diff_w(input int unsigned dw);
    return dw + 1;
  endfunction

  // Signed difference times zero-extended fraction.
  function automatic int unsigned prod_w(input int unsigned dw, input int unsigned fw);
    return dw + fw + 2;
  endfunction

  // Signed sum of unsigned sample, interpolated offset and signed bias.
  function automatic int unsigned sum_w(input int unsigned dw);
    return dw + 2;
  endfunction

endpackage

// File: rtl/sat_clip_u.sv
// Clips a signed value into the unsigned range [0, 2^OW-1] and flags when
// clipping was applied.
module sat_clip_u
  import lerp_pipe_pkg::*;
#(
  parameter int unsigned IW = 10,
  parameter int unsigned OW = 8
) (
  input  logic signed [IW-1:0] val_i,
  output logic        [OW-1:0] val_o,
  output logic                 sat_o
);

  localparam logic signed [IW-1:0] LoS = IW'(ClipLo);
  localparam logic signed [IW-1:0] HiS = IW'(clip_hi(OW));

  logic below;
  logic above;

  always_comb begin
    below = val_i < LoS;
    above = val_i > HiS;
    sat_o = below | above;
    if (below) begin
      val_o = '0;
    end else if (above) begin
      val_o = '1;
    end else begin
      val_o = val_i[OW-1:0];
    end
  end

endmodule

// File: rtl/lerp_pipe.sv
// Three-stage valid/ready linear interpolator: y = clip(p0 + round((p1-p0)*frac) + bias),
// with a saturating counter of clipped outputs accepted downstream.
module lerp_pipe
  import lerp_pipe_pkg::*;
#(
  parameter int unsigned DW = DefDw,
  parameter int unsigned FW = DefFw,
  parameter int unsigned CW = DefCw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] p0,
  input  logic [DW-1:0] p1,
  input  logic [FW-1:0] frac,
  input  logic [DW-1:0] bias,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] y,
  output logic          sat,
  input  logic          sat_clr,
  output logic [CW-1:0] sat_count
);

  localparam int unsigned DiffW = diff_w(DW);
  localparam int unsigned ProdW = prod_w(DW, FW);
  localparam int unsigned SumW  = sum_w(DW);

  localparam logic signed [ProdW-1:0] RoundC = {{(ProdW-1){1'b0}}, 1'b1} << (FW - 1);

  // Stage 1
  logic                    v1_q, v1_d;
  logic signed [DiffW-1:0] d1_q, d1_d;
  logic        [DW-1:0]    p0_1_q, p0_1_d;
  logic        [FW-1:0]    frac1_q, frac1_d;
  logic        [DW-1:0]    bias1_q, bias1_d;
  // Stage 2
  logic                    v2_q, v2_d;
  logic signed [SumW-1:0]  q2_q, q2_d;
  logic        [DW-1:0]    p0_2_q, p0_2_d;
  logic        [DW-1:0]    bias2_q, bias2_d;
  // Stage 3
  logic                    v3_q, v3_d;
  logic        [DW-1:0]    y_q, y_d;
  logic                    sat_q, sat_d;
  logic        [CW-1:0]    sat_count_q, sat_count_d;

  logic en1, en2, en3;

  logic signed [DiffW-1:0] diff;
  logic signed [ProdW-1:0] prod;
  logic signed [ProdW-1:0] prod_rnd;
  logic signed [SumW-1:0]  q_rnd;
  logic signed [SumW-1:0]  p0_ext;
  logic signed [SumW-1:0]  bias_ext;
  logic signed [SumW-1:0]  sum3;
  logic        [DW-1:0]    clip_y;
  logic                    clip_sat;

  // A stage loads when empty or when its successor drains it this cycle.
  always_comb begin
    en3 = ~v3_q | m_ready;
    en2 = ~v2_q | en3;
    en1 = ~v1_q | en2;
  end

  assign s_ready   = en1;
  assign m_valid   = v3_q;
  assign y         = y_q;
  assign sat       = sat_q;
  assign sat_count = sat_count_q;

  always_comb begin
    diff     = $signed({{(DiffW-DW){1'b0}}, p1}) - $signed({{(DiffW-DW){1'b0}}, p0});
    prod     = $signed(ProdW'(d1_q)) * $signed({{(ProdW-FW){1'b0}}, frac1_q});
    prod_rnd = prod + RoundC;
    // Magnitude after the shift never exceeds 2^DW-1, so SumW bits suffice.
    q_rnd    = SumW'(prod_rnd >>> FW);
    p0_ext   = $signed({{(SumW-DW){1'b0}}, p0_2_q});
    bias_ext = $signed({{(SumW-DW){bias2_q[DW-1]}}, bias2_q});
    sum3     = p0_ext + q2_q + bias_ext;
  end

  sat_clip_u #(
    .IW(SumW),
    .OW(DW)
  ) u_clip (
    .val_i(sum3),
    .val_o(clip_y),
    .sat_o(clip_sat)
  );

  always_comb begin
    v1_d    = v1_q;
    d1_d    = d1_q;
    p0_1_d  = p0_1_q;
    frac1_d = frac1_q;
    bias1_d = bias1_q;
    v2_d    = v2_q;
    q2_d    = q2_q;
    p0_2_d  = p0_2_q;
    bias2_d = bias2_q;
    v3_d    = v3_q;
    y_d     = y_q;
    sat_d   = sat_q;

    if (en1) begin
      v1_d = s_valid;
      if (s_valid) begin
        d1_d    = diff;
        p0_1_d  = p0;
        frac1_d = frac;
        bias1_d = bias;
      end
    end
    if (en2) begin
      v2_d = v1_q;
      if (v1_q) begin
        q2_d    = q_rnd;
        p0_2_d  = p0_1_q;
        bias2_d = bias1_q;
      end
    end
    if (en3) begin
      v3_d = v2_q;
      if (v2_q) begin
        y_d   = clip_y;
        sat_d = clip_sat;
      end
    end
  end

  // Clear wins over a simultaneous increment; the count sticks at all-ones.
  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_count_d = '0;
    end else if (v3_q && m_ready && sat_q && !(&sat_count_q)) begin
      sat_count_d = sat_count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      d1_q        <= '0;
      p0_1_q      <= '0;
      frac1_q     <= '0;
      bias1_q     <= '0;
      v2_q        <= 1'b0;
      q2_q        <= '0;
      p0_2_q      <= '0;
      bias2_q     <= '0;
      v3_q        <= 1'b0;
      y_q         <= '0;
      sat_q       <= 1'b0;
      sat_count_q <= '0;
    end else begin
      v1_q        <= v1_d;
      d1_q        <= d1_d;
      p0_1_q      <= p0_1_d;
      frac1_q     <= frac1_d;
      bias1_q     <= bias1_d;
      v2_q        <= v2_d;
      q2_q        <= q2_d;
      p0_2_q      <= p0_2_d;
      bias2_q     <= bias2_d;
      v3_q        <= v3_d;
      y_q         <= y_d;
      sat_q       <= sat_d;
      sat_count_q <= sat_count_d;
    end
  end

endmodule

// File: tb/tb_lerp_pipe.sv
// Self-checking bench for lerp_pipe: arithmetic reference model with an in-order
// scoreboard, directed corner cases and a randomized stream with stalls and resets.
module tb_lerp_pipe;

  localparam int unsigned DW = 8;
  localparam int unsigned FW = 8;
  localparam int unsigned CW = 4;
  localparam int CntMax = (1 << CW) - 1;
  localparam int YMax   = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] p0;
  logic [DW-1:0] p1;
  logic [FW-1:0] frac;
  logic [DW-1:0] bias;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] y;
  logic          sat;
  logic          sat_clr;
  logic [CW-1:0] sat_count;

  typedef struct {
    int y;
    bit s;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            m_cnt    = 0;
  bit            chk_rst  = 1'b0;
  bit            held_v   = 1'b0;
  logic [DW-1:0] held_y;
  logic          held_s;

  always #5 clk = ~clk;

  lerp_pipe #(
    .DW(DW),
    .FW(FW),
    .CW(CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .p0       (p0),
    .p1       (p1),
    .frac     (frac),
    .bias     (bias),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .y        (y),
    .sat      (sat),
    .sat_clr  (sat_clr),
    .sat_count(sat_count)
  );

  task automatic chk(input string nm, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Plain integer arithmetic; >>> on int is an arithmetic (floor) shift.
  function automatic exp_t model(input int a, input int b, input int f, input int bi);
    exp_t e;
    int   s;
    s   = a + ((((b - a) * f) + (1 << (FW - 1))) >>> FW) + bi;
    e.s = (s < 0) || (s > YMax);
    e.y = (s < 0) ? 0 : ((s > YMax) ? YMax : s);
    return e;
  endfunction

  // Outputs and inputs are stable at the falling edge; the model is advanced here
  // to the state it must hold after the following rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (chk_rst) begin
      chk("rst_m_valid", m_valid, 0);
      chk("rst_y", y, 0);
      chk("rst_sat", sat, 0);
      chk("rst_sat_count", sat_count, 0);
      chk("rst_s_ready", s_ready, 1);
    end
    if (held_v) begin
      chk("stall_m_valid", m_valid, 1);
      chk("stall_y", y, held_y);
      chk("stall_sat", sat, held_s);
    end
    if (rst_n) chk("sat_count", sat_count, m_cnt);

    if (!rst_n) begin
      exp_q.delete();
      m_cnt   = 0;
      held_v  = 1'b0;
      chk_rst = 1'b1;
    end else begin
      chk_rst = 1'b0;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("y", y, e.y);
          chk("sat", sat, e.s);
          if (!sat_clr && e.s && m_cnt < CntMax) m_cnt++;
        end
      end
      if (sat_clr) m_cnt = 0;
      held_v = m_valid && !m_ready;
      held_y = y;
      held_s = sat;
      if (s_valid && s_ready) exp_q.push_back(model(p0, p1, frac, $signed(bias)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic send(input int a, input int b, input int f, input int bi);
    bit ok;
    ok      = 1'b0;
    s_valid = 1'b1;
    p0      = DW'(a);
    p1      = DW'(b);
    frac    = FW'(f);
    bias    = DW'(bi);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      ok = s_ready;
      step();
      if (ok) break;
    end
    s_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  // Counts falling edges until m_valid; returns at that falling edge.
  task automatic wait_out(output int n);
    n = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (m_valid) begin
        n = k;
        break;
      end
    end
    if (n == 0) chk("wait_out_timeout", 0, 1);
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (exp_q.size() == 0 && !m_valid) break;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_m_valid", m_valid, 0);
  endtask

  initial begin
    int   n;
    int   idx;
    bit   saw_low;
    logic [DW-1:0] sp0 [10];
    logic [DW-1:0] sp1 [10];
    logic [FW-1:0] sfr [10];
    logic [DW-1:0] sbi [10];

    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    sat_clr = 1'b0;
    p0      = '0;
    p1      = '0;
    frac    = '0;
    bias    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Midpoint, three-cycle latency
    send(10, 20, 128, 0);
    wait_out(n);
    chk("lat_mid", n, 3);
    chk("y_mid", y, 15);
    chk("sat_mid", sat, 0);
    step();

    // Negative difference rounds toward +inf: -6400+128 >>> 8 = -25
    send(200, 100, 64, 0);
    wait_out(n);
    chk("y_neg", y, 175);
    chk("sat_neg", sat, 0);
    step();

    // Clip high then clip low
    send(250, 250, 0, 50);
    wait_out(n);
    chk("y_clip_hi", y, 255);
    chk("sat_clip_hi", sat, 1);
    step();
    @(negedge clk);
    chk("cnt_after_hi", sat_count, 1);
    step();
    send(5, 77, 0, -20);
    wait_out(n);
    chk("y_clip_lo", y, 0);
    chk("sat_clip_lo", sat, 1);
    step();
    @(negedge clk);
    chk("cnt_after_lo", sat_count, 2);
    step();

    // Counter sticks at max, then clear wins over a saturated transfer
    for (int i = 0; i < 14; i++) send(250, 250, 0, 50);
    drain();
    @(negedge clk);
    chk("cnt_stick", sat_count, CntMax);
    step();
    m_ready = 1'b0;
    send(250, 250, 0, 50);
    wait_out(n);
    step();
    sat_clr = 1'b1;
    m_ready = 1'b1;
    step();
    sat_clr = 1'b0;
    @(negedge clk);
    chk("cnt_clr_prio", sat_count, 0);
    step();

    // Ten samples with downstream stalled in cycles 2..7
    for (int i = 0; i < 10; i++) begin
      sp0[i] = DW'($urandom);
      sp1[i] = DW'($urandom);
      sfr[i] = FW'($urandom);
      sbi[i] = DW'($urandom);
    end
    idx     = 0;
    saw_low = 1'b0;
    for (int c = 0; c < 60 && idx < 10; c++) begin
      m_ready = !(c >= 2 && c <= 7);
      s_valid = 1'b1;
      p0      = sp0[idx];
      p1      = sp1[idx];
      frac    = sfr[idx];
      bias    = sbi[idx];
      @(negedge clk);
      if (!s_ready) saw_low = 1'b1;
      if (s_ready) idx++;
      step();
    end
    s_valid = 1'b0;
    chk("stall_s_ready_fell", saw_low, 1);
    chk("stall_all_sent", idx, 10);
    drain();

    // Reset with three samples in flight
    m_ready = 1'b0;
    send(1, 2, 3, 4);
    send(250, 250, 0, 50);
    send(5, 6, 7, 8);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("flush_m_valid", m_valid, 0);
    chk("flush_sat_count", sat_count, 0);
    step();
    m_ready = 1'b1;
    send(10, 20, 128, 0);
    wait_out(n);
    chk("lat_after_flush", n, 3);
    chk("y_after_flush", y, 15);
    step();

    // Randomized traffic with stalls, clears and occasional resets
    for (int c = 0; c < 3000; c++) begin
      rst_n   = ($urandom_range(0, 399) != 0);
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      sat_clr = ($urandom_range(0, 49) == 0);
      p0      = DW'($urandom);
      p1      = DW'($urandom);
      frac    = FW'($urandom);
      bias    = DW'($urandom);
      step();
    end
    rst_n   = 1'b1;
    sat_clr = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
